// File: rtl/pixel_array_ctrl.sv
// Global-shutter pixel array controller: erase -> expose -> ramp conversion -> row-by-row readout over valid/ready.
// Optional build macro PIXEL_TEST_PATTERN_EN adds a test_pattern input that replaces captured pixels with (r*COLS+c).
module pixel_array_ctrl #(
    parameter int ROWS         = 2,
    parameter int COLS         = 2,
    parameter int DATA_W       = 8,
    parameter int ERASE_CYCLES = 5,
    parameter int READ_CYCLES  = 2,
    parameter int EXP_W        = 16,
    localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     continuous,
    input  logic [EXP_W-1:0]         expose_len,
`ifdef PIXEL_TEST_PATTERN_EN
    input  logic                     test_pattern,
`endif
    output logic                     erase,
    output logic                     expose,
    output logic                     convert,
    output logic [ROWS-1:0]          read,
    output logic [DATA_W-1:0]        ramp_data,
    input  logic [COLS*DATA_W-1:0]   pix_in,
    output logic [COLS*DATA_W-1:0]   out_data,
    output logic [ROW_W-1:0]         out_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ,
        S_ROW_OUT,
        S_DONE
    } state_t;

    // Phase counter is wide enough for the exposure length and the full ramp.
    localparam int CNT_W = (EXP_W > 31) ? EXP_W + 1 : 32;
    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'((2 ** DATA_W) - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [EXP_W-1:0]        r_exp_len;
    logic [ROW_W-1:0]        r_row;
    logic [COLS*DATA_W-1:0]  r_buf;
    logic [15:0]             r_frame_cnt;
    logic [CNT_W-1:0]        w_exp_last;
    logic                    w_row_last;
    logic                    w_accept;
    logic                    w_enter;
    logic                    w_cnt_run;
    logic [COLS*DATA_W-1:0]  w_capture;

    assign w_exp_last = CNT_W'(r_exp_len) - CNT_W'(1);
    assign w_row_last = (r_row == ROW_W'(ROWS - 1));
    assign w_accept   = (r_state == S_ROW_OUT) && out_ready;
    assign w_enter    = (w_next != r_state);
    assign w_cnt_run  = (r_state == S_ERASE) || (r_state == S_EXPOSE) ||
                        (r_state == S_CONVERT) || (r_state == S_READ);
    assign frame_cnt  = r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        erase      = 1'b0;
        expose     = 1'b0;
        convert    = 1'b0;
        read       = '0;
        ramp_data  = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_row    = '0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_ERASE;
                end
            end
            S_ERASE: begin
                erase = 1'b1;
                if (r_cnt == ERASE_LAST) begin
                    w_next = S_EXPOSE;
                end
            end
            S_EXPOSE: begin
                expose = 1'b1;
                if (r_cnt == w_exp_last) begin
                    w_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                convert   = 1'b1;
                ramp_data = r_cnt[DATA_W-1:0];
                if (r_cnt == CONV_LAST) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                read = ROWS'(1) << r_row;
                if (r_cnt == READ_LAST) begin
                    w_next = S_ROW_OUT;
                end
            end
            S_ROW_OUT: begin
                out_valid = 1'b1;
                out_data  = r_buf;
                out_row   = r_row;
                if (out_ready) begin
                    w_next = w_row_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                w_next     = continuous ? S_ERASE : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef PIXEL_TEST_PATTERN_EN
    logic                    r_tp;
    logic [COLS*DATA_W-1:0]  w_pattern;

    always_comb begin
        w_pattern = '0;
        for (int c = 0; c < COLS; c++) begin
            w_pattern[c*DATA_W +: DATA_W] = DATA_W'(int'(r_row) * COLS + c);
        end
        w_capture = r_tp ? w_pattern : pix_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tp <= 1'b0;
        end else if (w_enter && (w_next == S_READ)) begin
            r_tp <= test_pattern;
        end
    end
`else
    assign w_capture = pix_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_exp_len   <= '0;
            r_row       <= '0;
            r_buf       <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_enter) begin
                r_cnt <= '0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Exposure length is frozen for the whole phase; zero means one cycle.
            if (w_enter && (w_next == S_EXPOSE)) begin
                r_exp_len <= (expose_len == '0) ? EXP_W'(1) : expose_len;
            end

            if (w_enter && (w_next == S_ERASE)) begin
                r_row <= '0;
            end else if (w_accept && !w_row_last) begin
                r_row <= r_row + ROW_W'(1);
            end

            if ((r_state == S_READ) && (r_cnt == READ_LAST)) begin
                r_buf <= w_capture;
            end

            if (r_state == S_DONE) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench for pixel_array_ctrl (2x2, 8-bit); row outputs go through a scoreboard queue.
module tb_pixel_array_ctrl;

    localparam int ROWS   = 2;
    localparam int COLS   = 2;
    localparam int DATA_W = 8;
    localparam int EXP_W  = 16;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic                    continuous;
    logic [EXP_W-1:0]        expose_len;
    logic                    erase;
    logic                    expose;
    logic                    convert;
    logic [ROWS-1:0]         read;
    logic [DATA_W-1:0]       ramp_data;
    logic [COLS*DATA_W-1:0]  pix_in;
    logic [COLS*DATA_W-1:0]  out_data;
    logic [0:0]              out_row;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;
    logic                    frame_done;
    logic [15:0]             frame_cnt;
`ifdef PIXEL_TEST_PATTERN_EN
    logic                    test_pattern;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        row;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         sb_e;
    logic [15:0] row_val[2];
    logic [15:0] junk;
    int          n_checks = 0;
    int          n_errors = 0;

    pixel_array_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W),
        .ERASE_CYCLES(5), .READ_CYCLES(2), .EXP_W(EXP_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .expose_len(expose_len),
`ifdef PIXEL_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .erase(erase), .expose(expose), .convert(convert), .read(read),
        .ramp_data(ramp_data), .pix_in(pix_in), .out_data(out_data),
        .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel array model: a row drives the bus only while its read line is up.
    always @(posedge clk) junk <= 16'($urandom);
    assign pix_in = (read == 2'b01) ? row_val[0] :
                    (read == 2'b10) ? row_val[1] : junk;

    always begin
        @(negedge clk);
        #1;
        if (!reset && out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: row %0d data %h, required no output", out_row, out_data);
            end else begin
                sb_e = sb_q.pop_front();
                if (out_data !== sb_e.data || out_row !== sb_e.row) begin
                    n_errors++;
                    $display("FAIL sb_row: got row %0d data %h, required row %0d data %h",
                             out_row, out_data, sb_e.row, sb_e.data);
                end
            end
        end
    end

    task automatic arm_rows(input logic [15:0] v0, input logic [15:0] v1);
        row_val[0] = v0;
        row_val[1] = v1;
        sb_q.push_back('{data: v0, row: 1'b0});
        sb_q.push_back('{data: v1, row: 1'b1});
    endtask

    task automatic observe_frame(input int mid_len, input bit poke_start, input bit clear_cont,
                                 output int n_er, output int n_ex, output int n_cv,
                                 output int n_r0, output int n_r1, output int ramp_err,
                                 output int excl_err, output int lat, output bit got_done);
        int cyc = 0;
        int first = -1;
        int ctl;
        n_er = 0; n_ex = 0; n_cv = 0; n_r0 = 0; n_r1 = 0;
        ramp_err = 0; excl_err = 0; lat = 0; got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            if (clear_cont) continuous = 1'b0;
            cyc++;
            if (erase === 1'b1) begin
                n_er++;
                if (first < 0) first = cyc;
            end
            if (expose === 1'b1) begin
                n_ex++;
                if (mid_len >= 0 && n_ex == 2) expose_len = EXP_W'(mid_len);
            end
            if (convert === 1'b1) begin
                if (ramp_data !== DATA_W'(n_cv)) ramp_err++;
                n_cv++;
                if (poke_start && n_cv == 1) start = 1'b1;
            end else if (ramp_data !== '0) begin
                ramp_err++;
            end
            if (read === 2'b01) n_r0++;
            if (read === 2'b10) n_r1++;
            ctl = int'(erase) + int'(expose) + int'(convert) + int'(read != '0);
            if (ctl > 1 || !$onehot0(read)) excl_err++;
            if (frame_done === 1'b1) begin
                got_done = 1'b1;
                lat = cyc - first + 1;
            end
        end
        n_checks++;
        if (!got_done) begin
            n_errors++;
            $display("FAIL frame_timeout: no frame_done after %0d cycles, required one", cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; continuous = 1'b0; expose_len = 16'd10; out_ready = 1'b1;
        row_val[0] = '0; row_val[1] = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_errors++; $display("FAIL reset_status: busy %b done %b, required 0 0", busy, frame_done);
        end
        n_checks++;
        if ({erase, expose, convert, read, ramp_data} !== '0) begin
            n_errors++; $display("FAIL reset_ctrl: %b %b %b %b %h, required all 0", erase, expose, convert, read, ramp_data);
        end
        n_checks++;
        if ({out_valid, out_data, out_row} !== '0) begin
            n_errors++; $display("FAIL reset_out: valid %b data %h row %0d, required 0", out_valid, out_data, out_row);
        end
        n_checks++;
        if (frame_cnt !== 16'd0) begin
            n_errors++; $display("FAIL reset_cnt: got %0d, required 0", frame_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_frame();
        int er, ex, cv, r0, r1, re, xe, lat;
        bit got;
        expose_len = 16'd10;
        arm_rows(16'h1234, 16'h5678);
        @(negedge clk); start = 1'b1;
        observe_frame(-1, 1'b0, 1'b0, er, ex, cv, r0, r1, re, xe, lat, got);
        n_checks++; if (er != 5)   begin n_errors++; $display("FAIL basic_erase: got %0d, required 5", er); end
        n_checks++; if (ex != 10)  begin n_errors++; $display("FAIL basic_expose: got %0d, required 10", ex); end
        n_checks++; if (cv != 256) begin n_errors++; $display("FAIL basic_convert: got %0d, required 256", cv); end
        n_checks++; if (re != 0)   begin n_errors++; $display("FAIL basic_ramp: %0d bad cycles, required 0", re); end
        n_checks++; if (r0 != 2 || r1 != 2) begin n_errors++; $display("FAIL basic_read: got %0d/%0d, required 2/2", r0, r1); end
        n_checks++; if (xe != 0)   begin n_errors++; $display("FAIL basic_excl: %0d bad cycles, required 0", xe); end
        n_checks++; if (lat != 278) begin n_errors++; $display("FAIL basic_latency: got %0d, required 278", lat); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_errors++; $display("FAIL basic_after: busy %b done %b, required 0 0", busy, frame_done);
        end
        n_checks++; if (frame_cnt !== 16'd1) begin n_errors++; $display("FAIL basic_cnt: got %0d, required 1", frame_cnt); end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        int bad = 0;
        expose_len = 16'd2;
        arm_rows(16'hA5C3, 16'h0FF0);
        out_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        while (out_valid !== 1'b1 && cyc < 1000) begin
            @(negedge clk); start = 1'b0; cyc++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid: got %b, required 1", out_valid); end
        for (int i = 0; i < 20; i++) begin
            if (!(out_valid === 1'b1 && out_data === 16'hA5C3 && out_row === 1'b0 && read === 2'b00)) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad); end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || read !== 2'b10) begin
            n_errors++; $display("FAIL bp_accept: valid %b read %b, required 0 10", out_valid, read);
        end
        cyc = 0;
        while (frame_done !== 1'b1 && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd1) begin
            n_errors++; $display("FAIL bp_done: done %b cnt %0d, required 1 1", frame_done, frame_cnt);
        end
        @(negedge clk);
        n_checks++; if (frame_cnt !== 16'd2) begin n_errors++; $display("FAIL bp_cnt: got %0d, required 2", frame_cnt); end
    endtask

    task automatic test_expose_len();
        int er, ex, cv, r0, r1, re, xe, lat;
        bit got;
        expose_len = 16'd0;
        arm_rows(16'h1111, 16'h2222);
        @(negedge clk); start = 1'b1;
        observe_frame(-1, 1'b0, 1'b0, er, ex, cv, r0, r1, re, xe, lat, got);
        n_checks++; if (ex != 1)    begin n_errors++; $display("FAIL exp0_len: got %0d, required 1", ex); end
        n_checks++; if (lat != 269) begin n_errors++; $display("FAIL exp0_latency: got %0d, required 269", lat); end
        expose_len = 16'd10;
        arm_rows(16'h3344, 16'h5566);
        @(negedge clk); start = 1'b1;
        observe_frame(3, 1'b0, 1'b0, er, ex, cv, r0, r1, re, xe, lat, got);
        n_checks++; if (ex != 10) begin n_errors++; $display("FAIL exp_midchange: got %0d, required 10", ex); end
        @(negedge clk);
        n_checks++; if (frame_cnt !== 16'd4) begin n_errors++; $display("FAIL exp_cnt: got %0d, required 4", frame_cnt); end
    endtask

    task automatic test_continuous();
        int er, ex, cv, r0, r1, re, xe, lat;
        bit got;
        int idle_bad = 0;
        expose_len = 16'd1;
        continuous = 1'b1;
        for (int f = 0; f < 3; f++) arm_rows(16'h9A9B, 16'hC0DE);
        @(negedge clk); start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            observe_frame(-1, 1'b1, (f == 2), er, ex, cv, r0, r1, re, xe, lat, got);
            n_checks++;
            if (lat != 269 || er != 5) begin
                n_errors++; $display("FAIL cont_frame%0d: latency %0d erase %0d, required 269 5", f, lat, er);
            end
        end
        @(negedge clk);
        n_checks++; if (frame_cnt !== 16'd7) begin n_errors++; $display("FAIL cont_cnt: got %0d, required 7", frame_cnt); end
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0) idle_bad++;
            @(negedge clk);
        end
        n_checks++;
        if (idle_bad != 0) begin n_errors++; $display("FAIL cont_stop: %0d busy cycles, required 0", idle_bad); end
    endtask

    task automatic test_reset_mid();
        int er, ex, cv, r0, r1, re, xe, lat;
        bit got;
        int cyc = 0;
        int bad = 0;
        expose_len = 16'd4;
        row_val[0] = 16'hDEAD; row_val[1] = 16'hFACE;
        @(negedge clk); start = 1'b1;
        while (!(convert === 1'b1 && ramp_data === 8'h40) && cyc < 1000) begin
            @(negedge clk); start = 1'b0; cyc++;
        end
        n_checks++;
        if (ramp_data !== 8'h40) begin n_errors++; $display("FAIL rst_reach: ramp %h, required 40", ramp_data); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, frame_done, erase, expose, convert, read, ramp_data, out_valid, out_data, out_row, frame_cnt} !== '0) begin
            n_errors++; $display("FAIL rst_mid: busy %b done %b conv %b ramp %h cnt %0d, required all 0",
                                 busy, frame_done, convert, ramp_data, frame_cnt);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL rst_quiet: %0d bad cycles, required 0", bad); end
        arm_rows(16'hBEEF, 16'h0102);
        @(negedge clk); start = 1'b1;
        observe_frame(-1, 1'b0, 1'b0, er, ex, cv, r0, r1, re, xe, lat, got);
        n_checks++;
        if (re != 0 || cv != 256 || ex != 4) begin
            n_errors++; $display("FAIL rst_rerun: ramp errs %0d conv %0d exp %0d, required 0 256 4", re, cv, ex);
        end
        @(negedge clk);
        n_checks++; if (frame_cnt !== 16'd1) begin n_errors++; $display("FAIL rst_cnt: got %0d, required 1", frame_cnt); end
    endtask

`ifdef PIXEL_TEST_PATTERN_EN
    task automatic test_pattern_mode();
        int er, ex, cv, r0, r1, re, xe, lat;
        bit got;
        expose_len = 16'd3;
        test_pattern = 1'b1;
        row_val[0] = 16'($urandom); row_val[1] = 16'($urandom);
        sb_q.push_back('{data: 16'h0100, row: 1'b0});
        sb_q.push_back('{data: 16'h0302, row: 1'b1});
        @(negedge clk); start = 1'b1;
        observe_frame(-1, 1'b0, 1'b0, er, ex, cv, r0, r1, re, xe, lat, got);
        n_checks++;
        if (r0 != 2 || r1 != 2) begin n_errors++; $display("FAIL tp_read: got %0d/%0d, required 2/2", r0, r1); end
        test_pattern = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_drained();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin n_errors++; $display("FAIL sb_drain: %0d rows missing, required 0", sb_q.size()); end
    endtask

    initial begin
`ifdef PIXEL_TEST_PATTERN_EN
        test_pattern = 1'b0;
`endif
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_expose_len();
        test_continuous();
        test_reset_mid();
`ifdef PIXEL_TEST_PATTERN_EN
        test_pattern_mode();
`endif
        test_drained();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
